// File: rtl/risc32_bus_arbiter_pkg.sv
// Shared constants for the RISC32 unified-memory bus arbiter.
//   arb_state_e     : arbiter FSM encoding (IDLE / FETCH / DATA)
//   TIMEOUT_DEFAULT : default ack timeout in cycles
//   reg_bus_t       : latched request (address, store data, lanes, write)
//   tmr_cnt_t       : 8-bit timeout counter type
package risc32_bus_arbiter_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

    typedef logic [7:0] tmr_cnt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
    } reg_bus_t;

endpackage

// File: rtl/risc32_bus_arbiter_if.sv
// Bundle of the pipeline request ports and the unified-memory bus.
//   if_*   : instruction-fetch requester
//   mem_*  : load/store requester
//   bus_*  : unified memory side
//   slave  : view taken by the arbiter (serves both requesters, drives bus)
//   master : view taken by the surrounding pipeline and memory
interface risc32_bus_arbiter_if;

    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;

    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;

    logic        stallreq_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    modport slave (
        input  if_ce_i, if_addr_i,
        output if_data_o, if_ready_o,
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
        output mem_rdata_o, mem_ready_o,
        output stallreq_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, bus_err_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport master (
        output if_ce_i, if_addr_i,
        input  if_data_o, if_ready_o,
        output mem_ce_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
        input  mem_rdata_o, mem_ready_o,
        input  stallreq_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, bus_err_o,
        output bus_rdata_i, bus_ack_i
    );

endinterface

// File: rtl/risc32_bus_timer.sv
// Access timeout counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : restart the count at zero (new access granted)
//   en_i     : count one more cycle without acknowledge
//   expire_o : count has reached TIMEOUT-1
module risc32_bus_timer
    import risc32_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam tmr_cnt_t LAST = tmr_cnt_t'(TIMEOUT - 1);

    tmr_cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + tmr_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/risc32_bus_arbiter.sv
// Arbitrates the instruction-fetch and load/store requesters onto a single
// unified memory bus. Data accesses win simultaneous requests; each access
// is held on the bus until bus_ack_i or until the timeout expires, and the
// owner then receives a one-cycle ready pulse with the registered result.
//   clk, rst : clock, asynchronous active-high reset
//   arb      : request/response and memory bus signals (slave view)
//   TIMEOUT  : cycles to wait for bus_ack_i before aborting (1..255)
module risc32_bus_arbiter
    import risc32_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    risc32_bus_arbiter_if.slave  arb
);

    arb_state_e  state_q, state_d;
    reg_bus_t    lat_q, lat_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        err_q, err_d;

    logic owner;
    logic ack;
    logic expire;
    logic timeout;
    logic done;
    logic start;
    logic ign_mem;
    logic ign_if;
    logic tmr_en;

    assign owner   = (state_q != ST_IDLE);
    assign ack     = owner & arb.bus_ack_i;
    // Acknowledge takes priority over an expiry in the same cycle.
    assign timeout = owner & ~arb.bus_ack_i & expire;
    assign done    = ack | timeout;
    assign tmr_en  = owner & ~arb.bus_ack_i;

    // A requester still holds ce while its access completes and during its
    // ready pulse; treat it as satisfied so the same request is not reissued.
    assign ign_mem = mem_ready_q | (done & (state_q == ST_DATA));
    assign ign_if  = if_ready_q  | (done & (state_q == ST_FETCH));

    risc32_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start),
        .en_i     (tmr_en),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        err_d       = 1'b0;
        start       = 1'b0;

        if (done) begin
            err_d = timeout;
            if (state_q == ST_DATA) begin
                mem_ready_d = 1'b1;
                mem_rdata_d = (ack && !lat_q.we) ? arb.bus_rdata_i : 32'h0;
            end else begin
                if_ready_d = 1'b1;
                if_data_d  = ack ? arb.bus_rdata_i : 32'h0;
            end
        end

        // Grant decision: from IDLE, or back-to-back as the current access ends.
        if (!owner || done) begin
            if (arb.mem_ce_i && !ign_mem) begin
                state_d = ST_DATA;
                start   = 1'b1;
                lat_d   = '{addr:  arb.mem_addr_i,
                            wdata: arb.mem_wdata_i,
                            sel:   arb.mem_sel_i,
                            we:    arb.mem_we_i};
            end else if (arb.if_ce_i && !ign_if) begin
                state_d = ST_FETCH;
                start   = 1'b1;
                lat_d   = '{addr:  arb.if_addr_i,
                            wdata: 32'h0,
                            sel:   SEL_WORD,
                            we:    1'b0};
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            err_q       <= err_d;
        end
    end

    // Bus outputs are gated by ownership so they fall with the state on reset.
    assign arb.bus_req_o   = owner;
    assign arb.bus_we_o    = owner & lat_q.we;
    assign arb.bus_addr_o  = owner ? lat_q.addr  : 32'h0;
    assign arb.bus_wdata_o = owner ? lat_q.wdata : 32'h0;
    assign arb.bus_sel_o   = owner ? lat_q.sel   : 4'h0;
    assign arb.bus_err_o   = err_q;

    assign arb.if_data_o   = if_data_q;
    assign arb.if_ready_o  = if_ready_q;
    assign arb.mem_rdata_o = mem_rdata_q;
    assign arb.mem_ready_o = mem_ready_q;

    assign arb.stallreq_o  = (arb.mem_ce_i & ~mem_ready_q) | (arb.if_ce_i & ~if_ready_q);

endmodule
